// File: rtl/axi_store_writer_pkg.sv
// AXI4 encodings and store-size helpers shared by the decode, memory and cache write paths.
package axi_store_writer_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } store_size_t;

  function automatic logic [7:0] strb_mask(store_size_t size);
    logic [7:0] mask;
    case (size)
      SIZE_BYTE:   mask = 8'h01;
      SIZE_HALF:   mask = 8'h03;
      SIZE_WORD:   mask = 8'h0F;
      default:     mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Natural alignment: low size bits of the address must be zero.
  function automatic logic is_misaligned(logic [2:0] addr_lo, store_size_t size);
    logic mis;
    case (size)
      SIZE_BYTE:   mis = 1'b0;
      SIZE_HALF:   mis = addr_lo[0];
      SIZE_WORD:   mis = |addr_lo[1:0];
      default:     mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/axi_store_writer_if.sv
// Store request/done handshake plus the AXI4 AW/W/B channels of the store initiator.
interface axi_store_writer_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  import axi_store_writer_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  store_size_t           req_size;
  logic                  done_valid;
  logic                  done_err;
  logic                  busy;

  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awlock;
  logic [3:0]            m_axi_awcache;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;

  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  logic [ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  modport master (
    input  req_valid, req_addr, req_data, req_size,
    output req_ready, done_valid, done_err, busy,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output req_valid, req_addr, req_data, req_size,
    input  req_ready, done_valid, done_err, busy,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/axi_store_writer_lane_align.sv
// Places a right-aligned store onto 64-bit byte lanes; purely combinational, zero latency.
module axi_store_writer_lane_align
  import axi_store_writer_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  store_size_t size,
  input  logic [63:0] data,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata,
  output logic        misaligned
);

  assign wstrb      = strb_mask(size) << addr_lo;
  assign wdata      = data << {addr_lo, 3'b000};
  assign misaligned = is_misaligned(addr_lo, size);

endmodule

// File: rtl/axi_store_writer.sv
// Single-beat AXI4 store initiator: done pulse 3 cycles after acceptance with a zero-wait slave.
// Backpressure: req_ready only in IDLE; AW/W valids are held with stable payload until their handshake.
module axi_store_writer
  import axi_store_writer_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int WRITE_ID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  axi_store_writer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_B,
    ST_DONE
  } state_t;

  localparam logic [ID_WIDTH-1:0] AWID = ID_WIDTH'(WRITE_ID);

  state_t                state;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [2:0]            awsize_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  done_valid_q;
  logic                  done_err_q;

  logic [7:0]            lane_strb;
  logic [63:0]           lane_data;
  logic                  lane_misaligned;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;

  axi_store_writer_lane_align u_lane_align (
    .addr_lo    (bus.req_addr[2:0]),
    .size       (bus.req_size),
    .data       (bus.req_data),
    .wstrb      (lane_strb),
    .wdata      (lane_data),
    .misaligned (lane_misaligned)
  );

  assign aw_hs = awvalid_q && bus.m_axi_awready;
  assign w_hs  = wvalid_q && bus.m_axi_wready;
  assign b_hs  = bready_q && bus.m_axi_bvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      awaddr_q     <= '0;
      awsize_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            awaddr_q <= bus.req_addr;
            awsize_q <= {1'b0, bus.req_size};
            wdata_q  <= lane_data;
            wstrb_q  <= lane_strb;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            // Misaligned stores complete with an error without touching the bus.
            if (lane_misaligned) begin
              state        <= ST_DONE;
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b1;
            end else begin
              state     <= ST_SEND;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state    <= ST_WAIT_B;
            bready_q <= 1'b1;
          end
        end
        ST_WAIT_B: begin
          if (b_hs) begin
            bready_q     <= 1'b0;
            state        <= ST_DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= (bus.m_axi_bresp != AXI_RESP_OKAY) || (bus.m_axi_bid != AWID);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done_valid = done_valid_q;
  assign bus.done_err   = done_err_q;

  assign bus.m_axi_awid    = AWID;
  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awlen   = AXI_LEN_SINGLE;
  assign bus.m_axi_awsize  = awsize_q;
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = 4'd0;
  assign bus.m_axi_awprot  = 3'd0;
  assign bus.m_axi_awvalid = awvalid_q;

  assign bus.m_axi_wdata  = wdata_q;
  assign bus.m_axi_wstrb  = wstrb_q;
  assign bus.m_axi_wlast  = wvalid_q;
  assign bus.m_axi_wvalid = wvalid_q;

  assign bus.m_axi_bready = bready_q;

endmodule

// File: doc/axi_store_writer.md
Name: axi_store_writer

Overview:
- AXI4 write-channel initiator for the memory stage: converts one store request (address, data, size) into a single-beat AW/W transaction and waits for the B response.
- It is the write-side counterpart of the fetch stage's AR/R read initiator, and drives the m_axi_aw*/w*/b* ports of top.
- One transaction outstanding at a time; completion is reported to the pipeline as a one-cycle done pulse.

Parameters:
ID_WIDTH, 13, width of m_axi_awid/m_axi_bid
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, bus data width (only 64 supported)
STRB_WIDTH, DATA_WIDTH/8, write strobe width
WRITE_ID, 1, constant AWID value driven on every transaction

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  store request valid
req_ready  out  1  block can accept a request (state IDLE)
req_addr  in  ADDR_WIDTH  byte address of store
req_data  in  DATA_WIDTH  store data, right-aligned (LSB = first byte)
req_size  in  2  0=byte 1=half 2=word 3=double
done_valid  out  1  one-cycle pulse: store finished
done_err  out  1  valid with done_valid: misaligned, BRESP!=OKAY, or BID mismatch
busy  out  1  state != IDLE
m_axi_awid  out  ID_WIDTH  =WRITE_ID
m_axi_awaddr  out  ADDR_WIDTH  latched req_addr
m_axi_awlen  out  8  always 0
m_axi_awsize  out  3  {1'b0, req_size}
m_axi_awburst  out  2  2'b01 INCR
m_axi_awlock  out  1  0
m_axi_awcache  out  4  0
m_axi_awprot  out  3  0
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address accepted
m_axi_wdata  out  DATA_WIDTH  req_data << (8*addr[2:0])
m_axi_wstrb  out  STRB_WIDTH  size mask << addr[2:0]
m_axi_wlast  out  1  always 1 while wvalid
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data accepted
m_axi_bid  in  ID_WIDTH  response id
m_axi_bresp  in  2  response code
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  ready for response

Behaviour:
- Reset (async, active-high): state=IDLE; awvalid, wvalid, bready, done_valid, done_err = 0; busy=0; req_ready=1 once reset deasserts. Address/data registers cleared to 0.
- States: IDLE, SEND, WAIT_B, DONE.
- IDLE: req_ready=1. On req_valid, latch the request.
  - If aligned (addr mod 2^size == 0): go to SEND.
  - If misaligned: go to DONE with err=1 and no bus activity.
- SEND: awvalid and wvalid both assert the cycle after acceptance. Each channel deasserts independently on its own handshake (valid&&ready); an aw_done/w_done flag is kept per channel. Handshakes on both channels in the same cycle are legal. Once both flags are set (including when the second is set this cycle), go to WAIT_B.
- No valid signal deasserts before its handshake. AW/W payloads stay stable while valid.
- Strobe mask: size 0 -> 8'h01, 1 -> 8'h03, 2 -> 8'h0F, 3 -> 8'hFF, shifted left by addr[2:0]. Data is shifted left by 8*addr[2:0] and truncated to 64 bits.
- WAIT_B: bready=1. On bvalid, capture err = (bresp!=2'b00) || (bid!=WRITE_ID), then go to DONE. bvalid seen in SEND is ignored (bready=0 there).
- DONE: done_valid=1 for exactly one cycle with done_err; next state is IDLE. req_ready=0 in DONE, so back-to-back stores have a minimum spacing of 4 cycles with zero-wait slaves.
- Latency with zero-wait slave: acceptance at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, done_valid at cycle 3.
- Reset mid-transaction: all valids drop immediately and the in-flight transaction is abandoned. The interconnect is reset by the same signal.
- awaddr carries the full unaligned byte address. awsize matches req_size.

Decomposition:
- Shared package axi_pkg: AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, size encodings, and the store_size_t enum used by decode/memory.
- The state enum stays local.
- One natural sub-module, store_lane_align: combinational (addr[2:0], size, data) -> (wstrb, wdata, misaligned). It is reusable by a future cache write path.

Test Plan:
- Byte store, addr=0x1003, data=0xAB, zero-wait slave, bresp=0 -> wstrb=8'h08, wdata=0x00000000AB000000, awsize=0, done_valid at cycle 3 with err=0.
- Double store, addr=0x2000, data=0x1122334455667788 -> wstrb=8'hFF, wdata unchanged, awlen=0, wlast=1, err=0.
- Stalled slave: awready delayed 5 cycles, wready delayed 2 cycles -> wvalid drops after cycle 2, awvalid stays asserted with stable awaddr until its handshake, bready asserts only after both handshakes.
- Misaligned word, addr=0x1002, size=2 -> no awvalid/wvalid ever; done_valid=1 and done_err=1 one cycle after acceptance.
- Error response: bresp=2'b10 (and separately bid=0x5) -> done_err=1; next request accepted immediately after done.
- Reset asserted during SEND with awvalid=1 -> awvalid, wvalid, busy go 0 asynchronously, with no done pulse; after release, req_ready=1.
